// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
package uart_rx_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int PRESCALE_W_DEF = 6;

  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_ERR_CHK = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    START   = ST_START,
    DATA    = ST_DATA,
    PARITY  = ST_PARITY,
    STOP    = ST_STOP,
    ERR_CHK = ST_ERR_CHK
  } state_e;

  function automatic bit presc_legal(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge counter (clock index within a bit) and bit counter for the UART receiver.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic                  load1_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]      bit_cnt_o,
  output logic                  wrap_o
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;

  assign wrap_o = (edge_cnt_q == (prescale_i - PRESCALE_W'(1)));

  // Clear beats load-1 beats counting; load-1 makes the start-detect cycle edge 0.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clear_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (load1_i) begin
      edge_cnt_d = PRESCALE_W'(1);
      bit_cnt_d  = '0;
    end else if (en_i) begin
      if (wrap_o) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver sequencing FSM: start detection, bit timing, checker enables, frame qualification.
// Optional errored-frame counter enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  start_glitch,
  input  logic                  par_err,
  input  logic                  stop_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  data_samp_en,
  output logic                  start_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stop_chk_en,
  output logic                  data_valid,
  output logic [7:0]            err_cnt
);

  localparam int BIT_W = $clog2(DATA_W + 4);

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_cnt_w;
  logic [BIT_W-1:0]      bit_cnt_w;
  logic                  last_edge;
  logic                  cnt_en, cnt_clr, cnt_load1;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_err;
  logic                  glitch_abort;

  assign frame_err    = stop_err | (par_en & par_err);
  assign cnt_en       = (state_q != IDLE);
  assign glitch_abort = start_glitch && (bit_cnt_w == BIT_W'(1)) && (edge_cnt_w == '0);

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_W      (BIT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en_i       (cnt_en),
    .clear_i    (cnt_clr),
    .load1_i    (cnt_load1),
    .prescale_i (prescale),
    .edge_cnt_o (edge_cnt_w),
    .bit_cnt_o  (bit_cnt_w),
    .wrap_o     (last_edge)
  );

  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_load1    = 1'b0;
    data_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_in) begin
          state_d   = START;
          cnt_load1 = 1'b1;
        end
      end
      START: begin
        if (last_edge) state_d = DATA;
      end
      DATA: begin
        // The start checker's verdict lands on edge 0 of the first data bit.
        if (glitch_abort) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (last_edge && (bit_cnt_w == BIT_W'(DATA_W))) begin
          state_d = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last_edge) state_d = STOP;
      end
      STOP: begin
        if (last_edge) state_d = ERR_CHK;
      end
      ERR_CHK: begin
        data_valid_d = ~frame_err;
        // A low line here is the next start bit, this cycle being its edge 0.
        if (!rx_in) begin
          state_d   = START;
          cnt_load1 = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == ERR_CHK) && frame_err && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt_q <= 8'h00;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

  assign edge_cnt     = edge_cnt_w;
  assign data_samp_en = (state_q != IDLE);
  assign start_chk_en = (state_q == START)  && last_edge;
  assign deser_en     = (state_q == DATA)   && last_edge;
  assign par_chk_en   = (state_q == PARITY) && last_edge;
  assign stop_chk_en  = (state_q == STOP)   && last_edge;
  assign data_valid   = data_valid_q;

  a_presc_legal: assert property (@(posedge clk) disable iff (!rst)
    (state_q != IDLE) |-> presc_legal(32'(prescale)));

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame timing, parity/stop errors, glitch abort, reset abort.
module tb_uart_rx_ctrl;

`ifdef UART_RX_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en, start_glitch, par_err, stop_err;
  logic [5:0] edge_cnt;
  logic       data_samp_en, start_chk_en, deser_en, par_chk_en, stop_chk_en, data_valid;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_err = 0;

  int n_deser, n_start, n_par, n_stop, n_dv;
  int first_deser, stop_cyc, par_cyc, dv_last, dv_prev;

  uart_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst_n),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .par_en       (par_en),
    .start_glitch (start_glitch),
    .par_err      (par_err),
    .stop_err     (stop_err),
    .edge_cnt     (edge_cnt),
    .data_samp_en (data_samp_en),
    .start_chk_en (start_chk_en),
    .deser_en     (deser_en),
    .par_chk_en   (par_chk_en),
    .stop_chk_en  (stop_chk_en),
    .data_valid   (data_valid),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (deser_en) begin
      if (n_deser == 0) first_deser = cyc;
      n_deser++;
    end
    if (start_chk_en) n_start++;
    if (par_chk_en) begin n_par++; par_cyc = cyc; end
    if (stop_chk_en) begin n_stop++; stop_cyc = cyc; end
    if (data_valid) begin n_dv++; dv_prev = dv_last; dv_last = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_deser = 0; n_start = 0; n_par = 0; n_stop = 0; n_dv = 0;
    first_deser = -1; stop_cyc = -1; par_cyc = -1; dv_last = -1; dv_prev = -1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, data LSB first, optional even parity and stop; t = start-detect cycle.
  task automatic send_frame(input logic [7:0] b, input int p, input bit par, output int t);
    logic [11:0] bits;
    int n;
    prescale = 6'(p);
    par_en   = par;
    bits     = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    n = 9;
    if (par) begin bits[n] = ^b; n++; end
    bits[n] = 1'b1;
    n++;
    t = cyc;
    for (int i = 0; i < n; i++) begin
      rx_in = bits[i];
      tick(p);
    end
    rx_in = 1'b1;
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 1000 && cyc < target; k++) tick(1);
  endtask

  initial begin
    int t, t2;
    rst_n = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0;
    start_glitch = 1'b0; par_err = 1'b0; stop_err = 1'b0;
    clr_mon();
    tick(3);
    chk("rst_samp_en", data_samp_en, 0);
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_enables", {start_chk_en, deser_en, par_chk_en, stop_chk_en}, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    tick(4);
    chk("idle_samp_en", data_samp_en, 0);

    // 1: clean frame, prescale 8, no parity
    clr_mon();
    send_frame(8'hA5, 8, 1'b0, t);
    tick(5);
    chk("t1_deser_cnt", n_deser, 8);
    chk("t1_first_deser", first_deser, t + 15);
    chk("t1_start_cnt", n_start, 1);
    chk("t1_par_cnt", n_par, 0);
    chk("t1_stop_cyc", stop_cyc, t + 79);
    chk("t1_dv_cnt", n_dv, 1);
    chk("t1_dv_cyc", dv_last, t + 81);
    chk("t1_err_cnt", err_cnt, exp_err);

    // 2: prescale 16 with parity, parity error forced
    clr_mon();
    par_err = 1'b1;
    send_frame(8'h3C, 16, 1'b1, t);
    tick(5);
    par_err = 1'b0;
    if (ERR_EN) exp_err = exp_err + 1;
    chk("t2_deser_cnt", n_deser, 8);
    chk("t2_par_cyc", par_cyc, t + 159);
    chk("t2_stop_cyc", stop_cyc, t + 175);
    chk("t2_dv_cnt", n_dv, 0);
    chk("t2_err_cnt", err_cnt, exp_err);

    // 2b: clean parity frame, then par_err ignored without parity (prescale 32)
    clr_mon();
    send_frame(8'h81, 16, 1'b1, t);
    tick(5);
    chk("t2b_dv_cyc", dv_last, t + 177);
    clr_mon();
    par_err = 1'b1;
    send_frame(8'h7E, 32, 1'b0, t);
    tick(5);
    par_err = 1'b0;
    chk("t2c_par_cnt", n_par, 0);
    chk("t2c_dv_cyc", dv_last, t + 321);
    chk("t2c_err_cnt", err_cnt, exp_err);

    // 3: short low pulse flagged as a glitch by the start checker
    clr_mon();
    prescale = 6'd8; par_en = 1'b0; start_glitch = 1'b1;
    t = cyc;
    rx_in = 1'b0;
    tick(1);
    chk("t3_edge_load1", edge_cnt, 1);
    chk("t3_samp_en", data_samp_en, 1);
    tick(2);
    rx_in = 1'b1;
    wait_cyc(t + 8);
    chk("t3_edge_wrap", edge_cnt, 0);
    chk("t3_in_data", data_samp_en, 1);
    tick(1);
    chk("t3_aborted", data_samp_en, 0);
    tick(100);
    start_glitch = 1'b0;
    chk("t3_start_cnt", n_start, 1);
    chk("t3_deser_cnt", n_deser, 0);
    chk("t3_dv_cnt", n_dv, 0);
    chk("t3_err_cnt", err_cnt, exp_err);

    // 4: back-to-back frames
    clr_mon();
    send_frame(8'h55, 8, 1'b0, t);
    send_frame(8'hAA, 8, 1'b0, t2);
    tick(5);
    chk("t4_second_start", t2, t + 80);
    chk("t4_start_cnt", n_start, 2);
    chk("t4_deser_cnt", n_deser, 16);
    chk("t4_dv_cnt", n_dv, 2);
    chk("t4_dv_first", dv_prev, t + 81);
    chk("t4_dv_gap", dv_last - dv_prev, 80);

    // 5: reset during the fourth data bit
    clr_mon();
    prescale = 6'd8;
    t = cyc;
    rx_in = 1'b0;
    tick(8);
    rx_in = 1'b1;
    wait_cyc(t + 39);
    chk("t5_pre_samp_en", data_samp_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_enables", {data_samp_en, start_chk_en, deser_en, par_chk_en, stop_chk_en}, 0);
    chk("t5_edge_cnt", edge_cnt, 0);
    chk("t5_dv", data_valid, 0);
    tick(2);
    rst_n = 1'b1;
    exp_err = 0;
    tick(100);
    chk("t5_deser_cnt", n_deser, 3);
    chk("t5_dv_cnt", n_dv, 0);
    chk("t5_idle", data_samp_en, 0);
    chk("t5_err_cnt", err_cnt, exp_err);

    // 6: 300 frames with stop errors
    clr_mon();
    stop_err = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send_frame(8'h0F, 8, 1'b0, t);
      tick(2);
    end
    stop_err = 1'b0;
    exp_err = ERR_EN ? 255 : 0;
    chk("t6_dv_cnt", n_dv, 0);
    chk("t6_stop_cnt", n_stop, 300);
    chk("t6_err_sat", err_cnt, exp_err);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
